// File: rtl/traffic_intersection_ctrl.sv
// Two-direction intersection controller with all-red clearance between directions.
// Defining PED_REQ_EN compiles in the pedestrian walk phase inserted after ALL_RED_NS.
module traffic_intersection_ctrl #(
    parameter int RED_CLR  = 2,
    parameter int GREEN_T  = 8,
    parameter int YELLOW_T = 3,
    parameter int WALK_T   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ped_req,
    output logic [1:0] ns_light,
    output logic [1:0] ew_light,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        ALL_RED_NS = 3'b000,
        NS_GREEN   = 3'b001,
        NS_YELLOW  = 3'b010,
        ALL_RED_EW = 3'b011,
        EW_GREEN   = 3'b100,
        EW_YELLOW  = 3'b101,
        WALK       = 3'b110
    } state_t;

    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_GREEN  = 2'b01;
    localparam logic [1:0] LIGHT_YELLOW = 2'b10;

    // A duration of 0 behaves as 1, so its terminal count is 0 as well.
    function automatic logic [7:0] last_count(input int t);
        logic [7:0] v;
        if (t <= 1) begin
            v = 8'd0;
        end else begin
            v = 8'(t - 1);
        end
        return v;
    endfunction

    localparam logic [7:0] RED_LAST    = last_count(RED_CLR);
    localparam logic [7:0] GREEN_LAST  = last_count(GREEN_T);
    localparam logic [7:0] YELLOW_LAST = last_count(YELLOW_T);
    localparam logic [7:0] WALK_LAST   = last_count(WALK_T);

    state_t     state_r;
    state_t     state_s;
    logic [7:0] cnt_r;
    logic [7:0] last_s;
    logic       done_s;
`ifdef PED_REQ_EN
    logic       enter_walk_s;
    logic       ped_pending_r;
    logic       ped_ack_r;
`else
    logic       unused_ped_req_s;
`endif

    // Terminal dwell count of the current state.
    always_comb begin
        last_s = RED_LAST;
        case (state_r)
            ALL_RED_NS, ALL_RED_EW: last_s = RED_LAST;
            NS_GREEN, EW_GREEN:     last_s = GREEN_LAST;
            NS_YELLOW, EW_YELLOW:   last_s = YELLOW_LAST;
            WALK:                   last_s = WALK_LAST;
            default:                last_s = RED_LAST;
        endcase
    end

    assign done_s = (cnt_r == last_s);

    // Next-state selection; the walk decision looks only at the registered request.
    always_comb begin
        state_s = state_r;
`ifdef PED_REQ_EN
        enter_walk_s = 1'b0;
`endif
        if (done_s) begin
            case (state_r)
                ALL_RED_NS: begin
`ifdef PED_REQ_EN
                    if (ped_pending_r) begin
                        state_s      = WALK;
                        enter_walk_s = 1'b1;
                    end else begin
                        state_s = NS_GREEN;
                    end
`else
                    state_s = NS_GREEN;
`endif
                end
                NS_GREEN:   state_s = NS_YELLOW;
                NS_YELLOW:  state_s = ALL_RED_EW;
                ALL_RED_EW: state_s = EW_GREEN;
                EW_GREEN:   state_s = EW_YELLOW;
                EW_YELLOW:  state_s = ALL_RED_NS;
                WALK:       state_s = NS_GREEN;
                default:    state_s = ALL_RED_NS;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ALL_RED_NS;
        end else begin
            state_r <= state_s;
        end
    end

    // Dwell counter, restarted on every state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= 8'd0;
        end else if (done_s) begin
            cnt_r <= 8'd0;
        end else begin
            cnt_r <= cnt_r + 8'd1;
        end
    end

`ifdef PED_REQ_EN
    // Pending request latch; a new request on the WALK-entry cycle survives the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ped_pending_r <= 1'b0;
        end else if (ped_req) begin
            ped_pending_r <= 1'b1;
        end else if (enter_walk_s) begin
            ped_pending_r <= 1'b0;
        end else begin
            ped_pending_r <= ped_pending_r;
        end
    end

    // Acknowledge pulse aligned with the first WALK cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ped_ack_r <= 1'b0;
        end else begin
            ped_ack_r <= enter_walk_s;
        end
    end

    assign ped_ack = ped_ack_r;
`else
    assign unused_ped_req_s = ped_req;
    assign ped_ack          = 1'b0;
`endif

    // Signal-head decode straight from the state register.
    always_comb begin
        ns_light = LIGHT_RED;
        ew_light = LIGHT_RED;
        walk     = 1'b0;
        case (state_r)
            NS_GREEN:  ns_light = LIGHT_GREEN;
            NS_YELLOW: ns_light = LIGHT_YELLOW;
            EW_GREEN:  ew_light = LIGHT_GREEN;
            EW_YELLOW: ew_light = LIGHT_YELLOW;
`ifdef PED_REQ_EN
            WALK:      walk = 1'b1;
`endif
            default: begin
                ns_light = LIGHT_RED;
                ew_light = LIGHT_RED;
            end
        endcase
    end

    assign phase = state_r;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Self-checking bench: spec vector table, corner sequences and a random run against a
// countdown-based reference model. Honours PED_REQ_EN the same way as the design.
module tb_traffic_intersection_ctrl;

    localparam int RED_CLR  = 2;
    localparam int GREEN_T  = 8;
    localparam int YELLOW_T = 3;
    localparam int WALK_T   = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       ped_req;
    logic [1:0] ns1, ew1, ns2, ew2;
    logic       walk1, ack1, walk2, ack2;
    logic [2:0] ph1, ph2;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    traffic_intersection_ctrl #(.RED_CLR(RED_CLR), .GREEN_T(GREEN_T),
                                .YELLOW_T(YELLOW_T), .WALK_T(WALK_T)) dut_a (
        .clk(clk), .reset(reset), .ped_req(ped_req), .ns_light(ns1), .ew_light(ew1),
        .walk(walk1), .ped_ack(ack1), .phase(ph1));

    traffic_intersection_ctrl #(.RED_CLR(RED_CLR), .GREEN_T(0),
                                .YELLOW_T(YELLOW_T), .WALK_T(WALK_T)) dut_b (
        .clk(clk), .reset(reset), .ped_req(ped_req), .ns_light(ns2), .ew_light(ew2),
        .walk(walk2), .ped_ack(ack2), .phase(ph2));

    // Reference model: phase id, cycles remaining in it, pending request, ack pulse.
    typedef struct {
        int ph;
        int rem;
        bit pend;
        bit ack;
    } mdl_t;

    typedef struct {
        bit req;
        int ph;
        bit ack;
        int len;
    } seg_t;

    mdl_t m1, m2;
    seg_t tbl[$];

    function automatic int eff(input int t);
        return (t < 1) ? 1 : t;
    endfunction

    function automatic int dur_of(input int ph, input int g);
        int d;
        case (ph)
            0, 3:    d = eff(RED_CLR);
            1, 4:    d = eff(g);
            2, 5:    d = eff(YELLOW_T);
            default: d = eff(WALK_T);
        endcase
        return d;
    endfunction

    function automatic mdl_t step(input mdl_t m, input bit rst, input bit req, input int g);
        mdl_t n;
        n = m;
        if (rst) begin
            n.ph = 0; n.rem = dur_of(0, g); n.pend = 1'b0; n.ack = 1'b0;
            return n;
        end
        n.ack = 1'b0;
        if (m.rem <= 1) begin
            n.ph = (m.ph == 6) ? 1 : (m.ph + 1) % 6;
`ifdef PED_REQ_EN
            if (m.ph == 0 && m.pend) begin
                n.ph = 6; n.ack = 1'b1; n.pend = 1'b0;
            end
`endif
            n.rem = dur_of(n.ph, g);
        end else begin
            n.rem = m.rem - 1;
        end
        if (req) n.pend = 1'b1;
        return n;
    endfunction

    function automatic logic [8:0] exp_obs(input int ph, input bit ack);
        logic [1:0] ns;
        logic [1:0] ew;
        logic [2:0] p;
        ns = 2'b00;
        ew = 2'b00;
        p  = 3'(ph);
        if (ph == 1) ns = 2'b01;
        if (ph == 2) ns = 2'b10;
        if (ph == 4) ew = 2'b01;
        if (ph == 5) ew = 2'b10;
        return {p, ns, ew, (ph == 6), ack};
    endfunction

    function automatic seg_t mk(input bit req, input int ph, input bit ack, input int len);
        seg_t s;
        s.req = req; s.ph = ph; s.ack = ack; s.len = len;
        return s;
    endfunction

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h required %h", name, $time, act, exp);
        end
    endtask

    // One clock: models advance on the same edge as the DUTs, outputs compared at negedge.
    task automatic tick();
        @(posedge clk);
        m1 = step(m1, reset, ped_req, GREEN_T);
        m2 = step(m2, reset, ped_req, 0);
        @(negedge clk);
        chk("model_a", {ph1, ns1, ew1, walk1, ack1}, exp_obs(m1.ph, m1.ack));
        chk("model_b", {ph2, ns2, ew2, walk2, ack2}, exp_obs(m2.ph, m2.ack));
        chk("excl_a", {7'd0, (ns1 != 2'b00) && (ew1 != 2'b00), (ns1 == 2'b11) || (ew1 == 2'b11)}, 9'd0);
        chk("excl_b", {7'd0, (ns2 != 2'b00) && (ew2 != 2'b00), (ns2 == 2'b11) || (ew2 == 2'b11)}, 9'd0);
    endtask

    initial begin
        reset   = 1'b1;
        ped_req = 1'b0;
        m1 = step('{default: 0}, 1'b1, 1'b0, GREEN_T);
        m2 = step('{default: 0}, 1'b1, 1'b0, 0);

        // Vector table: per-segment expected phase/ack with the request applied in it.
        tbl.push_back(mk(1'b0, 0, 1'b0, 2));
        tbl.push_back(mk(1'b0, 1, 1'b0, 8));
        tbl.push_back(mk(1'b0, 2, 1'b0, 3));
        tbl.push_back(mk(1'b0, 3, 1'b0, 2));
        tbl.push_back(mk(1'b0, 4, 1'b0, 3));
        tbl.push_back(mk(1'b1, 4, 1'b0, 1));
        tbl.push_back(mk(1'b0, 4, 1'b0, 4));
        tbl.push_back(mk(1'b0, 5, 1'b0, 3));
        tbl.push_back(mk(1'b0, 0, 1'b0, 2));
`ifdef PED_REQ_EN
        tbl.push_back(mk(1'b0, 6, 1'b1, 1));
        tbl.push_back(mk(1'b0, 6, 1'b0, 4));
`endif
        tbl.push_back(mk(1'b0, 1, 1'b0, 8));
        tbl.push_back(mk(1'b0, 2, 1'b0, 3));
        tbl.push_back(mk(1'b0, 3, 1'b0, 2));
        tbl.push_back(mk(1'b0, 4, 1'b0, 8));
        tbl.push_back(mk(1'b0, 5, 1'b0, 3));
        tbl.push_back(mk(1'b0, 0, 1'b0, 1));
        tbl.push_back(mk(1'b1, 0, 1'b0, 1));
        tbl.push_back(mk(1'b0, 1, 1'b0, 8));
        tbl.push_back(mk(1'b0, 2, 1'b0, 3));
        tbl.push_back(mk(1'b0, 3, 1'b0, 2));
        tbl.push_back(mk(1'b0, 4, 1'b0, 8));
        tbl.push_back(mk(1'b0, 5, 1'b0, 3));
        tbl.push_back(mk(1'b0, 0, 1'b0, 2));
`ifdef PED_REQ_EN
        tbl.push_back(mk(1'b0, 6, 1'b1, 1));
        tbl.push_back(mk(1'b0, 6, 1'b0, 4));
`endif
        tbl.push_back(mk(1'b0, 1, 1'b0, 1));

        @(negedge clk);
        repeat (3) tick();
        chk("reset_a", {ph1, ns1, ew1, walk1, ack1}, 9'd0);
        chk("reset_b", {ph2, ns2, ew2, walk2, ack2}, 9'd0);

        reset = 1'b0;
        foreach (tbl[k]) begin
            for (int j = 0; j < tbl[k].len; j++) begin
                chk("vec", {ph1, ns1, ew1, walk1, ack1}, exp_obs(tbl[k].ph, tbl[k].ack));
                ped_req = tbl[k].req;
                tick();
            end
        end
        ped_req = 1'b0;

        // Reset in the middle of EW_GREEN aborts at once.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (18) tick();
        chk("pre_abort", {5'd0, ph1, 1'b0}, {5'd0, 3'd4, 1'b0});
        reset = 1'b1;
        #1;
        chk("abort_async", {ph1, ns1, ew1, walk1, ack1}, 9'd0);
        @(negedge clk);
        tick();
        reset = 1'b0;

`ifdef PED_REQ_EN
        // Request held high: WALK every round, 31-cycle period.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ped_req = 1'b1;
        for (int i = 0; i < 66; i++) begin
            chk("hold", {7'd0, walk1, ack1},
                {7'd0, ((i % 31) >= 2) && ((i % 31) <= 6), (i % 31) == 2});
            tick();
        end
        ped_req = 1'b0;

        // Reset on the 3rd WALK cycle with a request pending.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ped_req = 1'b1;
        tick();
        tick();
        chk("walk_entry", {ph1, ns1, ew1, walk1, ack1}, exp_obs(6, 1'b1));
        tick();
        tick();
        chk("walk_third", {ph1, ns1, ew1, walk1, ack1}, exp_obs(6, 1'b0));
        reset   = 1'b1;
        ped_req = 1'b0;
        #1;
        chk("walk_abort", {ph1, ns1, ew1, walk1, ack1}, 9'd0);
        @(negedge clk);
        tick();
        chk("walk_abort_hold", {ph1, ns1, ew1, walk1, ack1}, 9'd0);
        reset = 1'b0;
        chk("post_rel0", {ph1, ns1, ew1, walk1, ack1}, exp_obs(0, 1'b0));
        tick();
        chk("post_rel1", {ph1, ns1, ew1, walk1, ack1}, exp_obs(0, 1'b0));
        tick();
        chk("post_rel_green", {ph1, ns1, ew1, walk1, ack1}, exp_obs(1, 1'b0));
`endif

        // Random requests and occasional resets, both instances against the model.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            ped_req = ($urandom_range(0, 7) == 0);
            reset   = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset   = 1'b0;
        ped_req = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/traffic_intersection_ctrl.md
TRAFFIC_INTERSECTION_CTRL -- requirements
Module: traffic_intersection_ctrl

Interface
REQ-001 Parameter RED_CLR, default 2: all-red clearance duration in cycles.
REQ-002 Parameter GREEN_T, default 8: green duration per direction in cycles.
REQ-003 Parameter YELLOW_T, default 3: yellow duration per direction in cycles.
REQ-004 Parameter WALK_T, default 5: pedestrian walk duration in cycles.
REQ-005 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Port ped_req, input, 1: pedestrian request, level-sampled every cycle.
REQ-008 Port ns_light, output, 2: north-south head; 00=Red, 01=Green, 10=Yellow; 11 never driven.
REQ-009 Port ew_light, output, 2: east-west head, same encoding as ns_light.
REQ-010 Port walk, output, 1: pedestrian walk indication.
REQ-011 Port ped_ack, output, 1: one-cycle pulse when a pending request is served.
REQ-012 Port phase, output, 3: current state encoding, for debug.

Function
REQ-013 The FSM SHALL have these states, encoded as shown:
- ALL_RED_NS=000
- NS_GREEN=001
- NS_YELLOW=010
- ALL_RED_EW=011
- EW_GREEN=100
- EW_YELLOW=101
- WALK=110
REQ-014 An 8-bit dwell counter SHALL start at 0 on state entry, increment each cycle, and end the state on the cycle it equals T-1; it then returns to 0.
REQ-015 Each state's T SHALL be its parameter:
- RED_CLR for ALL_RED_*
- GREEN_T for *_GREEN
- YELLOW_T for *_YELLOW
- WALK_T for WALK
REQ-016 Each duration SHALL be in the range 1..256; a value of 0 SHALL behave as 1.
REQ-017 The state sequence SHALL be ALL_RED_NS -> NS_GREEN -> NS_YELLOW -> ALL_RED_EW -> EW_GREEN -> EW_YELLOW -> ALL_RED_NS.
REQ-018 When ALL_RED_NS ends with ped_pending=1, the FSM SHALL enter WALK instead of NS_GREEN; WALK then ends into NS_GREEN.
REQ-019 The ped_pending register SHALL be set on any cycle with ped_req=1.
REQ-020 ped_pending SHALL be cleared on the cycle WALK is entered; if set and clear coincide, set wins.
REQ-021 The ALL_RED_NS exit decision SHALL use the registered ped_pending only; a request first sampled on the terminal cycle is served on the next round.
REQ-022 ped_ack SHALL be a registered pulse, high exactly the first cycle the FSM is in WALK.
REQ-023 Light outputs SHALL decode combinationally from the state register:
- only NS_GREEN/NS_YELLOW drive ns_light non-Red
- only EW_GREEN/EW_YELLOW drive ew_light non-Red
- walk=1 only in WALK
REQ-024 ns_light and ew_light SHALL never be non-Red in the same cycle.
REQ-025 Every transition between the two directions SHALL pass through an all-red state of RED_CLR cycles.

Reset
REQ-026 While reset is high: state=ALL_RED_NS, counter=0, ped_pending=0, ped_ack=0; hence ns_light=ew_light=00, walk=0, phase=000.
REQ-027 Reset asserted mid-state, including WALK, SHALL abort immediately and discard any pending request.
REQ-028 After reset deasserts, the first NS_GREEN cycle SHALL be RED_CLR cycles later.

Configuration
REQ-029 Macro PED_REQ_EN defined: pedestrian logic (REQ-018..022) SHALL be compiled in.
REQ-030 Macro PED_REQ_EN undefined:
- ped_req is ignored
- no ped_pending register
- WALK is unreachable
- walk=0 and ped_ack=0 constantly
- port list is unchanged

Verification
REQ-031 Defaults, no ped_req, release reset: ns_light=00 for 2 cycles, 01 for 8, 10 for 3; ew_light=00 for 2, 01 for 8, 10 for 3; period = 26 cycles, repeating.
REQ-032 PED_REQ_EN, ped_req pulsed 1 cycle during EW_GREEN: after ALL_RED_NS (2 cycles), walk=1 for 5 cycles, ped_ack high on the first of them, then NS_GREEN.
REQ-033 PED_REQ_EN, ped_req pulsed on the final ALL_RED_NS cycle: NS_GREEN entered (no WALK); WALK occurs after the next ALL_RED_NS.
REQ-034 PED_REQ_EN, ped_req held high continuously: WALK inserted every round; ped_ack pulses once per WALK; period = 31 cycles.
REQ-035 Reset asserted on the 3rd WALK cycle with a request pending: next cycle shows ALL_RED_NS, walk=0, ped_ack=0; after release, NS_GREEN follows in 2 cycles, no WALK.
REQ-036 GREEN_T=0, others default: each green lasts 1 cycle; every cycle checks ns_light/ew_light never both non-Red.
